// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver slice.
//   rx_state_e  : receiver FSM states (IDLE, START, DATA, STOP)
//   OVERSAMPLE  : ticks per bit period
//   MID_SAMPLE  : tick index at the middle of the start bit
//   baud_div()  : clock cycles per oversample tick (integer truncation)
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_SAMPLE = 7;

    function automatic int unsigned baud_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        return clk_freq / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial-line side of the UART receiver.
//   rx        : serial line, idles high (driven by master)
//   rx_data   : last received byte
//   rx_done   : one-clk strobe, rx_data valid in the same cycle
//   frame_err : one-clk strobe on a bad stop bit (framing check builds only)
// master = line driver / byte consumer, slave = receiver.
interface uart_rx_if;

    logic       rx;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;

    modport master (
        output rx,
        input  rx_data,
        input  rx_done,
        input  frame_err
    );

    modport slave (
        input  rx,
        output rx_data,
        output rx_done,
        output frame_err
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Free-running 16x oversample tick generator.
//   clk  : system clock
//   rst  : synchronous active-high reset, clears the divider
//   tick : one-clk pulse every CLK_FREQ/(BAUD*16) cycles
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned DIV = baud_div(CLK_FREQ, BAUD);
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling and mid-bit sampling.
//   clk : system clock
//   rst : synchronous active-high reset; aborts any byte in progress
//   bus : uart_rx_if.slave (rx in; rx_data, rx_done, frame_err out)
// Optional feature: define UART_RX_FRAME_CHECK_EN to drop bytes whose stop
// bit samples low and pulse frame_err instead; otherwise frame_err is 0 and
// the stop bit value is ignored.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);

    localparam logic [3:0] TMID  = 4'(MID_SAMPLE);
    localparam logic [3:0] TLAST = 4'(OVERSAMPLE - 1);

    // Two-flop synchronizer; resets to the idle line level.
    logic rx_meta_q;
    logic rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rx_s      <= rx_meta_q;
        end
    end

    logic tick;

    uart_baud_tick #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    rx_state_e  state_q, state_d;
    logic [3:0] tcnt_q, tcnt_d;
    logic [2:0] bcnt_q, bcnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q;
    logic       rx_done_q;
    logic       load;
`ifdef UART_RX_FRAME_CHECK_EN
    logic       ferr;
    logic       frame_err_q;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!rx_s) state_d = START;
            end
            START: begin
                // Still low at mid start bit => real start, else a glitch.
                if (tick && tcnt_q == TMID) state_d = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (tick && tcnt_q == TLAST && bcnt_q == 3'd7) state_d = STOP;
            end
            STOP: begin
                if (tick && tcnt_q == TLAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and strobe decode.
    always_comb begin
        tcnt_d  = tcnt_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        load    = 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
        ferr    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_s) tcnt_d = '0;
            end
            START: begin
                if (tick) tcnt_d = (tcnt_q == TMID) ? 4'd0 : tcnt_q + 4'd1;
            end
            DATA: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 4'd1;  // wraps 15 -> 0 at each sample
                    if (tcnt_q == TLAST) begin
                        shift_d = {rx_s, shift_q[7:1]};  // LSB arrives first
                        bcnt_d  = bcnt_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 4'd1;
                    if (tcnt_q == TLAST) begin
`ifdef UART_RX_FRAME_CHECK_EN
                        if (rx_s) begin
                            load = 1'b1;
                        end else begin
                            ferr = 1'b1;
                        end
`else
                        load = 1'b1;
`endif
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_q    <= '0;
            bcnt_q    <= '0;
            shift_q   <= '0;
            rx_data_q <= '0;
            rx_done_q <= 1'b0;
        end else begin
            tcnt_q    <= tcnt_d;
            bcnt_q    <= bcnt_d;
            shift_q   <= shift_d;
            rx_done_q <= load;
            if (load) rx_data_q <= shift_q;
        end
    end

`ifdef UART_RX_FRAME_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= ferr;
        end
    end

    assign bus.frame_err = frame_err_q;
`else
    assign bus.frame_err = 1'b0;
`endif

    assign bus.rx_data = rx_data_q;
    assign bus.rx_done = rx_done_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CLK_FREQ=1.6 MHz, BAUD=10 kbit/s
// (10 clk per tick, 160 clk per bit).
module tb_uart_rx;

    localparam int unsigned CLK_FREQ = 1_600_000;
    localparam int unsigned BAUD     = 10_000;
    localparam int          BIT      = 160;
    // 8 ticks to mid start + 8*16 data + 16 to mid stop = 152 ticks = 1520 clk,
    // plus synchronizer/detect and tick phase.
    localparam int          LAT_LO   = 1510;
    localparam int          LAT_HI   = 1535;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_rx_if bus ();

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
        int         fall;
    } exp_t;

    exp_t       exp_q[$];
    int         done_cyc[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         n_done = 0;
    int         n_ferr = 0;
    logic       rst_at_edge = 1'b1;
    logic       checking = 1'b0;
    logic       prev_done = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
    end

    // Compare process: every strobe must match the next expected event, and
    // rx_data may only move on rx_done or reset.
    always @(negedge clk) begin
        exp_t e;
        if (checking) begin
            if (rst_at_edge) begin
                check_eq("reset rx_data", bus.rx_data, 8'h00);
                check_eq("reset rx_done", bus.rx_done, 1'b0);
                check_eq("reset frame_err", bus.frame_err, 1'b0);
            end else begin
                check_eq("rx_done width", bus.rx_done & prev_done, 1'b0);
                if (bus.rx_done || bus.frame_err) begin
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected strobe (pending events)", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("strobe rx_done", bus.rx_done, !e.is_err);
                        check_eq("strobe frame_err", bus.frame_err, e.is_err);
                        check_eq("strobe rx_data", bus.rx_data, e.is_err ? prev_data : e.data);
                        check_range("latency", cyc - e.fall, LAT_LO, LAT_HI);
                    end
                    if (bus.rx_done) begin
                        n_done++;
                        done_cyc.push_back(cyc);
                    end
                    if (bus.frame_err) n_ferr++;
                end else begin
                    check_eq("rx_data stable", bus.rx_data, prev_data);
                end
            end
        end
        prev_done = bus.rx_done;
        prev_data = bus.rx_data;
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // stop_low > 0: stop bit low for that many clk (covers the mid-bit sample),
    // then high. rst_bit >= 0: pulse rst mid-way through that data bit.
    task automatic send_byte(input logic [7:0] b, input int stop_low, input int rst_bit);
        exp_t e;
        logic aborted;
        aborted = 1'b0;
        e.fall  = cyc;
        e.data  = b;
`ifdef UART_RX_FRAME_CHECK_EN
        e.is_err = (stop_low > 0);
`else
        e.is_err = 1'b0;
`endif
        bus.rx = 1'b0;
        clks(BIT);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            if (i == rst_bit) begin
                clks(BIT / 2);
                rst = 1'b1;
                clks(1);
                rst = 1'b0;
                clks(BIT / 2 - 1);
                aborted = 1'b1;
            end else begin
                clks(BIT);
            end
        end
        if (!aborted) exp_q.push_back(e);
        if (stop_low > 0) begin
            bus.rx = 1'b0;
            clks(stop_low);
            bus.rx = 1'b1;
            clks(BIT - stop_low);
        end else begin
            bus.rx = 1'b1;
            clks(BIT);
        end
    endtask

    int done_before;

    initial begin
        bus.rx = 1'b1;
        rst    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checking = 1'b1;
        clks(2);
        rst = 1'b0;
        clks(20);
        check_eq("idle rx_data", bus.rx_data, 8'h00);
        check_eq("idle rx_done", bus.rx_done, 1'b0);
        check_eq("idle frame_err", bus.frame_err, 1'b0);

        // Single byte.
        send_byte(8'h55, 0, -1);
        clks(200);
        check_eq("0x55 rx_data", bus.rx_data, 8'h55);
        check_eq("0x55 pulses", n_done, 1);
        check_eq("0x55 frame_err count", n_ferr, 0);

        // Back-to-back, no idle gap.
        send_byte(8'h55, 0, -1);
        send_byte(8'hA3, 0, -1);
        clks(200);
        check_eq("b2b rx_data", bus.rx_data, 8'hA3);
        check_eq("b2b pulses", n_done, 3);
        if (done_cyc.size() >= 3) check_range("b2b spacing", done_cyc[2] - done_cyc[1], 1590, 1610);

        // Short low pulse on the line: rejected as a glitch.
        bus.rx = 1'b0;
        clks(40);
        bus.rx = 1'b1;
        clks(300);
        check_eq("glitch pulses", n_done, 3);
        send_byte(8'h0F, 0, -1);
        clks(200);
        check_eq("0x0F rx_data", bus.rx_data, 8'h0F);
        check_eq("0x0F pulses", n_done, 4);

        // Bad stop bit.
        send_byte(8'h3C, 100, -1);
        clks(300);
`ifdef UART_RX_FRAME_CHECK_EN
        check_eq("bad stop rx_data held", bus.rx_data, 8'h0F);
        check_eq("bad stop frame_err count", n_ferr, 1);
        check_eq("bad stop pulses", n_done, 4);
`else
        check_eq("bad stop rx_data", bus.rx_data, 8'h3C);
        check_eq("bad stop frame_err count", n_ferr, 0);
        check_eq("bad stop pulses", n_done, 5);
`endif

        // Reset in the middle of data bit 3 of 0xFF.
        done_before = n_done;
        send_byte(8'hFF, 0, 3);
        clks(200);
        check_eq("abort rx_data", bus.rx_data, 8'h00);
        check_eq("abort pulses", n_done - done_before, 0);
        send_byte(8'h81, 0, -1);
        clks(200);
        check_eq("0x81 rx_data", bus.rx_data, 8'h81);
        check_eq("0x81 pulses", n_done - done_before, 1);

        check_eq("pending events", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receives 8N1 asynchronous serial bytes from the PC-side UART line and presents each byte as a parallel word with a one-cycle valid strobe. It is the stage directly upstream of the command-decode LUT, which turns each received byte into mode/start pulses for the sensor controllers. Reception uses 16× oversampling with mid-bit sampling, a two-flop input synchronizer and glitch rejection on the start bit.

## Interface
Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD, 9600: line rate in bit/s.

Ports:
- clk  input  1  system clock; one clock domain only.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  serial line from the pin; asynchronous to clk; idles high.
- rx_data  output  8  last correctly received byte, LSB first on the wire.
- rx_done  output  1  one-clk pulse; rx_data is valid in the same cycle.
- frame_err  output  1  one-clk pulse on a bad stop bit; only active when the framing-check macro is defined.

## Operation
- rx passes through 2 flip-flops before any use; the synchronized value is rx_s. The synchronizer resets to 1.
- Tick generator: counter modulo DIV = CLK_FREQ/(BAUD*16), using integer truncation. It emits a one-clk tick when the count reaches DIV-1. It is free-running and is cleared only by rst.
- FSM with states IDLE, START, DATA, STOP. tcnt is a 4-bit tick counter. bcnt is a 3-bit bit counter.
- IDLE: when rx_s = 0, clear tcnt and go to START.
- START: count ticks. At tcnt = 7 (mid start bit):
  - if rx_s = 0, clear tcnt and go to DATA;
  - if rx_s = 1, treat it as a glitch and return to IDLE with no output.
- DATA: at each tcnt = 15, sample rx_s into a shift register (right shift, new bit enters at bit 7) and increment bcnt. After the 8th sample (bcnt wraps 7→0), go to STOP.
- STOP: at tcnt = 15, sample rx_s.
  - Load rx_data from the shift register.
  - Pulse rx_done.
  - Go to IDLE. A new start bit is detected from the next cycle.
- rx_data holds its value between bytes. The downstream stage must consume it in the rx_done cycle or later, before the next rx_done.
- No receive FIFO and no backpressure. The downstream stage accepts one byte per rx_done unconditionally.

## Timing
- Reset values:
  - rx_data = 8'h00, rx_done = 0, frame_err = 0;
  - FSM = IDLE, tcnt = 0, bcnt = 0;
  - synchronizer flops = 1, tick counter = 0.
- rst has priority over every event, including a byte in progress. Any partial byte is discarded with no pulse.
- rx_done and the new rx_data update on the same clk edge. rx_done is high for exactly 1 clk.
- Latency from the pin's falling edge to rx_done is 9.5 bit periods, plus 2 clk (synchronizer), plus at most 1 tick period (tick phase).
- Start-bit glitch rejection: any low pulse shorter than about 8 ticks returns to IDLE.
- Back-to-back bytes with no idle gap are received without loss. The STOP→IDLE transition completes within 1 clk after the stop sample.
- The line held low permanently (break) yields repeated byte attempts. Their behaviour at the stop bit is governed by the Configuration section.

## Configuration
- Macro: UART_RX_FRAME_CHECK_EN.
- Defined: if the stop-bit sample is 0:
  - frame_err pulses for 1 clk;
  - rx_done stays 0;
  - rx_data is unchanged;
  - the FSM returns to IDLE.
- Not defined: the stop-bit value is ignored. rx_done and rx_data update for every byte. frame_err is tied to 0.

## Structure
- Package uart_pkg holds:
  - the FSM state enum (IDLE, START, DATA, STOP);
  - OVERSAMPLE = 16;
  - MID_SAMPLE = 7.
- Sub-module uart_baud_tick holds the tick counter. Its parameters are CLK_FREQ and BAUD, and its ports are clk, rst and tick. The FSM, synchronizer and shift register stay in uart_rx.

## Test plan
Use CLK_FREQ = 1_600_000 and BAUD = 10_000, giving DIV = 10 and a bit period of 160 clk.
- Reset, then drive the line with 0x55 → exactly one rx_done pulse, rx_data = 0x55, frame_err = 0.
- Drive 0x55 then 0xA3 back-to-back with no idle gap → two rx_done pulses about 1600 clk apart, carrying 0x55 then 0xA3.
- Pull rx low for 40 clk, then return it high → no rx_done, FSM back in IDLE. A following 0x0F is received correctly.
- Send 0x3C with the stop bit forced to 0:
  - with UART_RX_FRAME_CHECK_EN defined → frame_err = 1 for 1 clk, no rx_done, rx_data keeps its previous value;
  - without the macro → rx_done with rx_data = 0x3C.
- Assert rst for 1 clk in the middle of the 4th data bit of 0xFF → outputs 0 immediately, no pulse for that byte. A subsequent 0x81 gives rx_data = 0x81.
- Check that rx_done never lasts more than 1 clk across all scenarios, and that rx_data changes only in rx_done cycles.
